fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage: owns the program counter, issues one-at-a-time requests to instruction memory over a req/ack handshake, and presents the fetched instruction, its PC and PC+4 to the IF/ID pipeline register. It absorbs variable memory latency, holds a fetched instruction while decode is stalled, and discards in-flight responses made stale by a branch/jump redirect.

## Interface
- DATA_WIDTH, 32, instruction width
- PC_WIDTH, 32, program counter width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INS, 32'h0000_0013, instruction presented when no valid instruction (addi x0,x0,0)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  IF/ID not accepting this cycle (IF/ID en = !stall)
- redirect  in  1  taken branch/jump resolved downstream
- redirect_pc  in  PC_WIDTH  redirect target; bits [1:0] ignored (treated as 0)
- imem_req  out  1  fetch request valid
- imem_addr  out  PC_WIDTH  fetch address, stable while imem_req high and not acked
- imem_ack  in  1  response valid this cycle; may assert same cycle as imem_req
- imem_rdata  in  DATA_WIDTH  instruction, valid when imem_ack
- valid_out  out  1  ins_out/pc_out/pc_plus4_out hold a real instruction
- ins_out  out  DATA_WIDTH  instruction to IF/ID (NOP_INS when !valid_out)
- pc_out  out  PC_WIDTH  PC of ins_out
- pc_plus4_out  out  PC_WIDTH  pc_out + 4

## Operation
- Registers: pc, pend_pc (redirect target waiting out a stale request), hold_ins, state ∈ {FETCH, HOLD, DROP}.
- Transfer to IF/ID occurs on a rising edge where valid_out=1 and stall=0.
- FETCH: imem_req=1, imem_addr=pc, valid_out=imem_ack, ins_out=imem_rdata (combinational pass-through).
  - redirect: pc<=redirect_pc&~3; if imem_ack stay FETCH (response discarded), else pend_pc<=redirect_pc&~3, go DROP.
  - imem_ack & !stall: pc<=pc+4, stay FETCH.
  - imem_ack & stall: hold_ins<=imem_rdata, go HOLD.
  - no ack: stay, pc unchanged.
- HOLD: imem_req=0, valid_out=1, ins_out=hold_ins, pc_out=pc.
  - redirect: pc<=redirect_pc&~3, go FETCH (held instruction discarded).
  - !stall: pc<=pc+4, go FETCH.
- DROP: imem_req=1, imem_addr=pc (old address, kept stable), valid_out=0.
  - redirect: pend_pc<=redirect_pc&~3 (latest wins).
  - imem_ack: pc<=pend_pc (or new redirect target if redirect same cycle), go FETCH; response discarded.
- redirect has priority over stall; in any cycle with redirect=1, valid_out=0.
- pc_plus4_out = pc+4 modulo 2^PC_WIDTH; pc wraps from max to 0 silently.
- At most one request outstanding; a new request never issues before the prior ack.

## Timing
- rst=1 at an edge: state<=FETCH, pc<=RESET_PC, pend_pc<=RESET_PC, hold_ins<=NOP_INS. Instruction memory shares rst; any in-flight request is abandoned.
- While rst=1 outputs forced: imem_req=0, valid_out=0, ins_out=NOP_INS, pc_out=pc, pc_plus4_out=pc+4.
- First cycle after reset: imem_req=1, imem_addr=RESET_PC.
- Zero-wait memory (ack same cycle): one instruction per cycle, fetch-to-IF/ID latency 0 cycles (captured at the same edge).
- N-cycle memory: valid_out rises in the ack cycle; next request issues the cycle after.
- Redirect penalty: with zero-wait memory, target fetched the cycle after redirect; in DROP, target fetched the cycle after stale ack.
- stall released in HOLD: held instruction transfers at that edge; next fetch request the following cycle.

## Test plan
- Reset, zero-wait memory, no stall -> imem_addr 0,4,8,12 on consecutive cycles; valid_out=1 each cycle; pc_plus4_out=pc_out+4.
- 2-cycle memory latency -> imem_addr=0 held for 2 cycles, valid_out high only in ack cycle, then addr 4.
- stall=1 for 3 cycles when ack for pc=8 arrives -> HOLD, imem_req=0, ins_out=word@8 stable; on release transfers once, next addr 12.
- redirect to 0x100 while request for 0x20 outstanding (ack 2 cycles later) -> imem_addr stays 0x20 until ack, response dropped (valid_out=0), next addr 0x100.
- redirect to 0x203 in HOLD with stall=1 -> held instruction discarded, valid_out=0, next imem_addr=0x200.
- rst asserted mid-DROP -> next cycle imem_addr=RESET_PC, valid_out=0 until first ack; pc=0xFFFFFFFC fetch -> pc_plus4_out=0, next addr 0.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage. Owns the program counter, issues one request at a
// time to instruction memory over a req/ack handshake and presents the
// fetched instruction, its PC and PC+4 to the IF/ID pipeline register.
// Absorbs variable memory latency, holds a fetched instruction while decode
// is stalled, and discards in-flight responses made stale by a redirect.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   stall         IF/ID is not accepting this cycle
//   redirect      taken branch/jump resolved downstream
//   redirect_pc   redirect target (bits [1:0] ignored)
//   imem_req      fetch request valid
//   imem_addr     fetch address, stable until acked
//   imem_ack      response valid this cycle (may coincide with imem_req)
//   imem_rdata    instruction word, valid with imem_ack
//   valid_out     ins_out/pc_out/pc_plus4_out carry a real instruction
//   ins_out       instruction to IF/ID (NOP_INS when !valid_out)
//   pc_out        PC of ins_out
//   pc_plus4_out  pc_out + 4 (wraps modulo 2^PC_WIDTH)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INS    = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] ins_out,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [PC_WIDTH-1:0]   pc_plus4_out
);

  localparam logic [1:0] ST_FETCH = 2'b00;
  localparam logic [1:0] ST_HOLD  = 2'b01;
  localparam logic [1:0] ST_DROP  = 2'b10;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4'd4);

  logic [1:0]            state_r;
  logic [PC_WIDTH-1:0]   pc_r;
  logic [PC_WIDTH-1:0]   pend_pc_r;
  logic [DATA_WIDTH-1:0] hold_ins_r;

  logic [PC_WIDTH-1:0]   target_s;
  logic [PC_WIDTH-1:0]   pc_next4_s;
  logic                  req_s;
  logic                  valid_s;
  logic [DATA_WIDTH-1:0] ins_s;

  // Redirect targets are always word aligned.
  assign target_s   = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign pc_next4_s = pc_r + PC_STEP;

  // Request/valid/instruction selection; FETCH passes memory data straight through.
  always_comb begin
    req_s   = 1'b0;
    valid_s = 1'b0;
    ins_s   = NOP_INS;
    if (rst) begin
      req_s   = 1'b0;
      valid_s = 1'b0;
      ins_s   = NOP_INS;
    end else begin
      case (state_r)
        ST_FETCH: begin
          req_s   = 1'b1;
          // A response arriving with a redirect is already stale.
          valid_s = imem_ack & ~redirect;
          if (valid_s) begin
            ins_s = imem_rdata;
          end else begin
            ins_s = NOP_INS;
          end
        end
        ST_HOLD: begin
          req_s   = 1'b0;
          valid_s = ~redirect;
          if (valid_s) begin
            ins_s = hold_ins_r;
          end else begin
            ins_s = NOP_INS;
          end
        end
        ST_DROP: begin
          // Keep the stale request alive so the memory can finish it.
          req_s   = 1'b1;
          valid_s = 1'b0;
          ins_s   = NOP_INS;
        end
        default: begin
          req_s   = 1'b0;
          valid_s = 1'b0;
          ins_s   = NOP_INS;
        end
      endcase
    end
  end

  assign imem_req     = req_s;
  assign imem_addr    = pc_r;
  assign valid_out    = valid_s;
  assign ins_out      = ins_s;
  assign pc_out       = pc_r;
  assign pc_plus4_out = pc_next4_s;

  // Fetch FSM: PC, pending redirect target and held instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_FETCH;
      pc_r       <= RESET_PC;
      pend_pc_r  <= RESET_PC;
      hold_ins_r <= NOP_INS;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (redirect) begin
            if (imem_ack) begin
              // Request completed this cycle; fetch the target next.
              pc_r <= target_s;
            end else begin
              // Request still outstanding: keep its address stable and
              // remember the target until the stale ack arrives.
              pend_pc_r <= target_s;
              state_r   <= ST_DROP;
            end
          end else if (imem_ack && !stall) begin
            pc_r <= pc_next4_s;
          end else if (imem_ack && stall) begin
            hold_ins_r <= imem_rdata;
            state_r    <= ST_HOLD;
          end else begin
            pc_r <= pc_r;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            pc_r    <= target_s;
            state_r <= ST_FETCH;
          end else if (!stall) begin
            pc_r    <= pc_next4_s;
            state_r <= ST_FETCH;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_DROP: begin
          if (imem_ack) begin
            if (redirect) begin
              pc_r <= target_s;
            end else begin
              pc_r <= pend_pc_r;
            end
            state_r <= ST_FETCH;
          end else if (redirect) begin
            pend_pc_r <= target_s;
          end else begin
            state_r <= ST_DROP;
          end
        end
        default: begin
          state_r <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc4;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        valid_out;
  logic [31:0] ins_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;

  int checks = 0;
  int errors = 0;
  xfer_t exp_q[$];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .valid_out(valid_out),
    .ins_out(ins_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out)
  );

  // Memory contents: a simple address-derived pattern.
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model: returns the word at the requested address when acking.
  assign imem_rdata = imem_ack ? word(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic xfer_t mk(input logic [31:0] pc);
    xfer_t x;
    x.ins = word(pc);
    x.pc  = pc;
    x.pc4 = pc + 32'd4;
    return x;
  endfunction

  // One cycle: drive inputs just after the edge, check handshake at negedge.
  task automatic cyc(input logic ack, input logic stl, input logic red,
                     input logic [31:0] rpc, input logic e_req,
                     input logic [31:0] e_addr, input logic e_valid,
                     input logic push, input logic [31:0] push_pc);
    imem_ack    = ack;
    stall       = stl;
    redirect    = red;
    redirect_pc = rpc;
    if (push) exp_q.push_back(mk(push_pc));
    @(negedge clk);
    chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    if (e_req) chk("imem_addr", imem_addr, e_addr);
    chk("valid_out", {31'd0, valid_out}, {31'd0, e_valid});
    if (!e_valid) chk("ins_out_nop", ins_out, NOP);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every presented instruction is compared with the
  // queue head; it is retired only when IF/ID accepts it.
  always @(negedge clk) begin
    if (!rst && valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid pc_out=%h ins_out=%h at %0t", pc_out, ins_out, $time);
      end else begin
        chk("sb_ins", ins_out, exp_q[0].ins);
        chk("sb_pc", pc_out, exp_q[0].pc);
        chk("sb_pc4", pc_plus4_out, exp_q[0].pc4);
        if (!stall) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; imem_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_ins", ins_out, NOP);
    chk("rst_pc", pc_out, 32'h0000_0000);
    chk("rst_pc4", pc_plus4_out, 32'h0000_0004);
    rst = 1'b0;

    // Zero-wait memory, no stall: one instruction per cycle.
    cyc(1, 0, 0, 0, 1, 32'h00, 1, 1, 32'h00);
    cyc(1, 0, 0, 0, 1, 32'h04, 1, 1, 32'h04);
    cyc(1, 0, 0, 0, 1, 32'h08, 1, 1, 32'h08);
    cyc(1, 0, 0, 0, 1, 32'h0C, 1, 1, 32'h0C);
    // Two-cycle memory latency at 0x10.
    cyc(0, 0, 0, 0, 1, 32'h10, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h10, 1, 1, 32'h10);
    // Ack for 0x14 under stall: hold for three stalled cycles, then release.
    cyc(1, 1, 0, 0, 1, 32'h14, 1, 1, 32'h14);
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h18, 1, 1, 32'h18);
    cyc(1, 0, 0, 0, 1, 32'h1C, 1, 1, 32'h1C);
    // Redirect to 0x100 while the 0x20 request is outstanding.
    cyc(0, 0, 1, 32'h100, 1, 32'h20, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h20, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h20, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h100, 1, 1, 32'h100);
    // Two redirects during one stale request: the latest (0x401 -> 0x400) wins.
    cyc(0, 0, 1, 32'h300, 1, 32'h104, 0, 0, 0);
    cyc(1, 0, 1, 32'h401, 1, 32'h104, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h400, 1, 1, 32'h400);
    // Redirect coinciding with an ack: response dropped, target next cycle.
    cyc(1, 0, 1, 32'h80, 1, 32'h404, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h80, 1, 1, 32'h80);
    // Redirect to 0x203 while holding under stall: held word discarded.
    cyc(1, 1, 0, 0, 1, 32'h84, 1, 1, 32'h84);
    void'(exp_q.pop_front());
    cyc(0, 1, 1, 32'h203, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h200, 1, 1, 32'h200);
    // Reset asserted in the middle of a DROP.
    cyc(0, 0, 1, 32'h500, 1, 32'h204, 0, 0, 0);
    rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 0, 0, 0, 1, 32'h00, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h00, 1, 1, 32'h00);
    // PC wrap: redirect to 0xFFFFFFFF (aligned to 0xFFFFFFFC), then wrap to 0.
    cyc(1, 0, 1, 32'hFFFF_FFFF, 1, 32'h04, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 1, 32'h00, 1, 1, 32'h00);
    cyc(0, 0, 0, 0, 1, 32'h04, 0, 0, 0);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
